// File: rtl/json_uart_pkg.sv
// Shared definitions for the JSON-over-UART command link (transmitter and
// receive parser): ASCII framing characters, the receive parser state
// encoding, key indices and small byte-classification helpers.
package json_uart_pkg;

    localparam logic [7:0] LBRACE = 8'h7B;
    localparam logic [7:0] RBRACE = 8'h7D;
    localparam logic [7:0] QUOTE  = 8'h22;
    localparam logic [7:0] COLON  = 8'h3A;
    localparam logic [7:0] COMMA  = 8'h2C;
    localparam logic [7:0] MINUS  = 8'h2D;
    localparam logic [7:0] DOT    = 8'h2E;
    localparam logic [7:0] CR     = 8'h0D;
    localparam logic [7:0] LF     = 8'h0A;
    localparam logic [7:0] SPACE  = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_KEY_OPEN,
        ST_KEY_CHAR,
        ST_KEY_CLOSE,
        ST_COLON,
        ST_VAL_SIGN,
        ST_VAL_INT,
        ST_VAL_FRAC,
        ST_EOL,
        ST_ERR
    } parse_state_e;

    typedef enum logic [1:0] {
        KEY_T,
        KEY_L,
        KEY_R,
        KEY_OTHER
    } key_idx_e;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic key_idx_e decode_key(input logic [7:0] c);
        case (c)
            8'h54:   return KEY_T;
            8'h4C:   return KEY_L;
            8'h52:   return KEY_R;
            default: return KEY_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/json_num_acc.sv
// Decimal number accumulator for one JSON value.
// Collects an optional sign, up to MAX_INT_DIGITS integer digits and up to two
// fractional digits, and presents the value scaled to hundredths.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr           start a new value (clears sign, digits and counters)
//   set_neg       mark the value negative
//   int_digit     strobe: 'digit' is an integer digit
//   frac_digit    strobe: 'digit' is a fractional digit
//   digit         BCD digit value
//   int_full      overflow flag: another integer digit would exceed MAX_INT_DIGITS
//   has_int       at least one integer digit has been seen
//   value         signed value in hundredths
//   int_part      integer part only, truncated to 8 bits
module json_num_acc #(
    parameter int VAL_W          = 16,
    parameter int MAX_INT_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    set_neg,
    input  logic                    int_digit,
    input  logic                    frac_digit,
    input  logic [3:0]              digit,
    output logic                    int_full,
    output logic                    has_int,
    output logic signed [VAL_W-1:0] value,
    output logic [7:0]              int_part
);

    localparam int CNT_W = $clog2(MAX_INT_DIGITS + 1);

    logic [VAL_W-1:0] acc_q, acc_d;
    logic [7:0]       int_q, int_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] int_cnt_q, int_cnt_d;
    logic [1:0]       frac_cnt_q, frac_cnt_d;

    function automatic logic [VAL_W-1:0] mac10(input logic [VAL_W-1:0] a,
                                               input logic [3:0]       d);
        return (a * VAL_W'(10)) + {{(VAL_W-4){1'b0}}, d};
    endfunction

    // Bring the digit string to hundredths, then apply the sign ("-0" stays 0).
    function automatic logic signed [VAL_W-1:0] scale_sign(input logic [VAL_W-1:0] a,
                                                           input logic [1:0]       f,
                                                           input logic             n);
        logic signed [VAL_W-1:0] m;
        case (f)
            2'd0:    m = signed'(a * VAL_W'(100));
            2'd1:    m = signed'(a * VAL_W'(10));
            default: m = signed'(a);
        endcase
        return n ? -m : m;
    endfunction

    assign int_full = (int_cnt_q == CNT_W'(MAX_INT_DIGITS));
    assign has_int  = (int_cnt_q != '0);
    assign value    = scale_sign(acc_q, frac_cnt_q, neg_q);
    assign int_part = int_q;

    always_comb begin
        acc_d      = acc_q;
        int_d      = int_q;
        neg_d      = neg_q;
        int_cnt_d  = int_cnt_q;
        frac_cnt_d = frac_cnt_q;
        if (clr) begin
            acc_d      = '0;
            int_d      = '0;
            neg_d      = 1'b0;
            int_cnt_d  = '0;
            frac_cnt_d = '0;
        end else begin
            if (set_neg) begin
                neg_d = 1'b1;
            end
            if (int_digit && !int_full) begin
                acc_d     = mac10(acc_q, digit);
                int_d     = (int_q * 8'd10) + {4'd0, digit};
                int_cnt_d = int_cnt_q + CNT_W'(1);
            end
            // Fraction digits beyond hundredths are truncated.
            if (frac_digit && (frac_cnt_q != 2'd2)) begin
                acc_d      = mac10(acc_q, digit);
                frac_cnt_d = frac_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            int_q      <= '0;
            neg_q      <= 1'b0;
            int_cnt_q  <= '0;
            frac_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            int_q      <= int_d;
            neg_q      <= neg_d;
            int_cnt_q  <= int_cnt_d;
            frac_cnt_q <= frac_cnt_d;
        end
    end

endmodule

// File: rtl/json_cmd_rx_parser.sv
// Byte-serial parser for JSON feedback frames such as
//   {"T":1,"L":-0.25,"R":0.25}\n
// Values are held in shadow registers while the frame is parsed and are
// published together only when the terminating '\n' arrives on a well-formed
// frame. Malformed or stalled frames are discarded with a frame_error pulse.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   rx_data      byte from uart_rx
//   rx_valid     one-cycle byte strobe
//   rx_ready     parser can accept a byte (every byte is consumed on arrival)
//   cmd_type     committed "T" value (integer part, 8 bits)
//   left_val     committed "L" value, signed hundredths
//   right_val    committed "R" value, signed hundredths
//   field_mask   {T,L,R} keys present in the last committed frame
//   frame_valid  one-cycle pulse when the committed outputs update
//   frame_error  one-cycle pulse on a malformed or timed-out frame
module json_cmd_rx_parser
    import json_uart_pkg::*;
#(
    parameter int VAL_W          = 16,
    parameter int MAX_INT_DIGITS = 2,
    parameter int TIMEOUT_CLKS   = 500_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [7:0]              cmd_type,
    output logic signed [VAL_W-1:0] left_val,
    output logic signed [VAL_W-1:0] right_val,
    output logic [2:0]              field_mask,
    output logic                    frame_valid,
    output logic                    frame_error
);

    localparam int GAP_W = $clog2(TIMEOUT_CLKS + 1);

    parse_state_e            state_q, state_d;
    key_idx_e                key_q, key_d;
    logic [7:0]              sh_t_q, sh_t_d;
    logic signed [VAL_W-1:0] sh_l_q, sh_l_d;
    logic signed [VAL_W-1:0] sh_r_q, sh_r_d;
    logic [2:0]              sh_mask_q, sh_mask_d;
    logic [7:0]              cmd_q, cmd_d;
    logic signed [VAL_W-1:0] left_q, left_d;
    logic signed [VAL_W-1:0] right_q, right_d;
    logic [2:0]              mask_q, mask_d;
    logic                    fv_q, fv_d;
    logic                    fe_q, fe_d;
    logic [GAP_W-1:0]        gap_q, gap_d;

    logic                    acc_clr, acc_neg, acc_int, acc_frac;
    logic                    acc_full, acc_has_int;
    logic signed [VAL_W-1:0] acc_value;
    logic [7:0]              acc_int_part;

    logic do_store, do_commit, do_err;
    logic byte_dig;

    json_num_acc #(
        .VAL_W          (VAL_W),
        .MAX_INT_DIGITS (MAX_INT_DIGITS)
    ) u_num_acc (
        .clk        (clk),
        .rst        (rst),
        .clr        (acc_clr),
        .set_neg    (acc_neg),
        .int_digit  (acc_int),
        .frac_digit (acc_frac),
        .digit      (rx_data[3:0]),
        .int_full   (acc_full),
        .has_int    (acc_has_int),
        .value      (acc_value),
        .int_part   (acc_int_part)
    );

    assign byte_dig = is_digit(rx_data);

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        sh_t_d    = sh_t_q;
        sh_l_d    = sh_l_q;
        sh_r_d    = sh_r_q;
        sh_mask_d = sh_mask_q;
        cmd_d     = cmd_q;
        left_d    = left_q;
        right_d   = right_q;
        mask_d    = mask_q;
        fv_d      = 1'b0;
        fe_d      = 1'b0;
        acc_clr   = 1'b0;
        acc_neg   = 1'b0;
        acc_int   = 1'b0;
        acc_frac  = 1'b0;
        do_store  = 1'b0;
        do_commit = 1'b0;
        do_err    = 1'b0;

        // Inter-byte gap only matters while a frame is in progress.
        gap_d = (rx_valid || (state_q == ST_IDLE)) ? '0 : gap_q + GAP_W'(1);

        if (rx_valid) begin
            // Spaces are insignificant everywhere except as the key character.
            if (!((rx_data == SPACE) && (state_q != ST_KEY_CHAR))) begin
                if ((rx_data == LF) &&
                    !(state_q inside {ST_IDLE, ST_EOL, ST_ERR})) begin
                    // Truncated frame: there is nothing left to skip, so go
                    // straight back to hunting for '{'.
                    state_d   = ST_IDLE;
                    fe_d      = 1'b1;
                    sh_mask_d = '0;
                end else begin
                    unique case (state_q)
                        ST_IDLE: begin
                            if (rx_data == LBRACE) begin
                                state_d   = ST_KEY_OPEN;
                                sh_mask_d = '0;
                            end
                        end
                        ST_KEY_OPEN: begin
                            if (rx_data == QUOTE)       state_d = ST_KEY_CHAR;
                            else if (rx_data == RBRACE) state_d = ST_EOL;
                            else                        do_err  = 1'b1;
                        end
                        ST_KEY_CHAR: begin
                            key_d   = decode_key(rx_data);
                            state_d = ST_KEY_CLOSE;
                        end
                        ST_KEY_CLOSE: begin
                            if (rx_data == QUOTE) state_d = ST_COLON;
                            else                  do_err  = 1'b1;
                        end
                        ST_COLON: begin
                            if (rx_data == COLON) begin
                                state_d = ST_VAL_SIGN;
                                acc_clr = 1'b1;
                            end else begin
                                do_err = 1'b1;
                            end
                        end
                        ST_VAL_SIGN: begin
                            if (rx_data == MINUS) begin
                                acc_neg = 1'b1;
                                state_d = ST_VAL_INT;
                            end else if (byte_dig) begin
                                acc_int = 1'b1;
                                state_d = ST_VAL_INT;
                            end else begin
                                do_err = 1'b1;
                            end
                        end
                        ST_VAL_INT: begin
                            if (byte_dig) begin
                                if (acc_full) do_err  = 1'b1;
                                else          acc_int = 1'b1;
                            end else if ((rx_data == DOT) && acc_has_int) begin
                                state_d = ST_VAL_FRAC;
                            end else if (((rx_data == COMMA) || (rx_data == RBRACE)) &&
                                         acc_has_int) begin
                                do_store = 1'b1;
                                state_d  = (rx_data == COMMA) ? ST_KEY_OPEN : ST_EOL;
                            end else begin
                                do_err = 1'b1;
                            end
                        end
                        ST_VAL_FRAC: begin
                            if (byte_dig) begin
                                acc_frac = 1'b1;
                            end else if ((rx_data == COMMA) || (rx_data == RBRACE)) begin
                                do_store = 1'b1;
                                state_d  = (rx_data == COMMA) ? ST_KEY_OPEN : ST_EOL;
                            end else begin
                                do_err = 1'b1;
                            end
                        end
                        ST_EOL: begin
                            if (rx_data == LF) begin
                                do_commit = 1'b1;
                                state_d   = ST_IDLE;
                            end else if (rx_data != CR) begin
                                do_err = 1'b1;
                            end
                        end
                        ST_ERR: begin
                            if (rx_data == LF) state_d = ST_IDLE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        end else if ((state_q != ST_IDLE) && (gap_q == GAP_W'(TIMEOUT_CLKS - 1))) begin
            state_d   = ST_IDLE;
            fe_d      = 1'b1;
            sh_mask_d = '0;
        end

        // A repeated key simply overwrites its shadow: last occurrence wins.
        if (do_store) begin
            case (key_q)
                KEY_T: begin
                    sh_t_d       = acc_int_part;
                    sh_mask_d[2] = 1'b1;
                end
                KEY_L: begin
                    sh_l_d       = acc_value;
                    sh_mask_d[1] = 1'b1;
                end
                KEY_R: begin
                    sh_r_d       = acc_value;
                    sh_mask_d[0] = 1'b1;
                end
                default: ;
            endcase
        end

        if (do_err) begin
            state_d   = ST_ERR;
            fe_d      = 1'b1;
            sh_mask_d = '0;
        end

        // Absent keys keep their previously committed value.
        if (do_commit) begin
            if (sh_mask_q[2]) cmd_d   = sh_t_q;
            if (sh_mask_q[1]) left_d  = sh_l_q;
            if (sh_mask_q[0]) right_d = sh_r_q;
            mask_d = sh_mask_q;
            fv_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            key_q     <= KEY_OTHER;
            sh_t_q    <= '0;
            sh_l_q    <= '0;
            sh_r_q    <= '0;
            sh_mask_q <= '0;
            cmd_q     <= '0;
            left_q    <= '0;
            right_q   <= '0;
            mask_q    <= '0;
            fv_q      <= 1'b0;
            fe_q      <= 1'b0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            sh_t_q    <= sh_t_d;
            sh_l_q    <= sh_l_d;
            sh_r_q    <= sh_r_d;
            sh_mask_q <= sh_mask_d;
            cmd_q     <= cmd_d;
            left_q    <= left_d;
            right_q   <= right_d;
            mask_q    <= mask_d;
            fv_q      <= fv_d;
            fe_q      <= fe_d;
            gap_q     <= gap_d;
        end
    end

    assign rx_ready    = ~rst;
    assign cmd_type    = cmd_q;
    assign left_val    = left_q;
    assign right_val   = right_q;
    assign field_mask  = mask_q;
    assign frame_valid = fv_q;
    assign frame_error = fe_q;

endmodule

// File: tb/tb_json_cmd_rx_parser.sv
module tb_json_cmd_rx_parser;

    localparam int VAL_W = 16;
    localparam int TMO   = 100;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [7:0]              rx_data = 8'h00;
    logic                    rx_valid = 1'b0;
    logic                    rx_ready;
    logic [7:0]              cmd_type;
    logic signed [VAL_W-1:0] left_val;
    logic signed [VAL_W-1:0] right_val;
    logic [2:0]              field_mask;
    logic                    frame_valid;
    logic                    frame_error;

    always #10 clk = ~clk;

    json_cmd_rx_parser #(
        .VAL_W          (VAL_W),
        .MAX_INT_DIGITS (2),
        .TIMEOUT_CLKS   (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .cmd_type    (cmd_type),
        .left_val    (left_val),
        .right_val   (right_val),
        .field_mask  (field_mask),
        .frame_valid (frame_valid),
        .frame_error (frame_error)
    );

    typedef struct {
        bit                      is_err;
        logic [7:0]              cmd;
        logic signed [VAL_W-1:0] l;
        logic signed [VAL_W-1:0] r;
        logic [2:0]              mask;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected committed state, advanced as frames are queued.
    logic [7:0]              exp_cmd  = 8'd0;
    logic signed [VAL_W-1:0] exp_l    = '0;
    logic signed [VAL_W-1:0] exp_r    = '0;
    logic [2:0]              exp_mask = 3'd0;

    task automatic push_valid(input logic [2:0] m, input int t, input int l, input int r);
        exp_t e;
        if (m[2]) exp_cmd = 8'(t);
        if (m[1]) exp_l = VAL_W'(l);
        if (m[0]) exp_r = VAL_W'(r);
        exp_mask = m;
        e.is_err = 1'b0; e.cmd = exp_cmd; e.l = exp_l; e.r = exp_r; e.mask = exp_mask;
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1; e.cmd = exp_cmd; e.l = exp_l; e.r = exp_r; e.mask = exp_mask;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (frame_valid || frame_error)) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL mon_unexpected: got pulse fv=%0b fe=%0b, required no pulse",
                         frame_valid, frame_error);
            end else begin
                mon_e = sb.pop_front();
                if (frame_valid !== ~mon_e.is_err || frame_error !== mon_e.is_err) begin
                    n_fail++;
                    $display("FAIL mon_kind: got fv=%0b fe=%0b, required fe=%0b",
                             frame_valid, frame_error, mon_e.is_err);
                end
                n_checks++;
                if (cmd_type !== mon_e.cmd) begin
                    n_fail++;
                    $display("FAIL mon_cmd: got %0d, required %0d", cmd_type, mon_e.cmd);
                end
                n_checks++;
                if (left_val !== mon_e.l) begin
                    n_fail++;
                    $display("FAIL mon_left: got %0d, required %0d", left_val, mon_e.l);
                end
                n_checks++;
                if (right_val !== mon_e.r) begin
                    n_fail++;
                    $display("FAIL mon_right: got %0d, required %0d", right_val, mon_e.r);
                end
                n_checks++;
                if (field_mask !== mon_e.mask) begin
                    n_fail++;
                    $display("FAIL mon_mask: got %b, required %b", field_mask, mon_e.mask);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending events, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    function automatic string fmt_val(input int v);
        int    a  = (v < 0) ? -v : v;
        string sg = (v < 0) ? "-" : "";
        if ((a % 100) == 0 && $urandom_range(0, 1) == 1)
            return $sformatf("%s%0d", sg, a / 100);
        if ((a % 10) == 0 && $urandom_range(0, 1) == 1)
            return $sformatf("%s%0d.%0d", sg, a / 100, (a % 100) / 10);
        return $sformatf("%s%0d.%02d", sg, a / 100, a % 100);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cmd_type, left_val, right_val, field_mask, frame_valid, frame_error} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cmd=%0d l=%0d r=%0d m=%b fv=%0b fe=%0b, required all 0",
                     cmd_type, left_val, right_val, field_mask, frame_valid, frame_error);
        end
        n_checks++;
        if (rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: got %0b, required 0", rx_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_high: got %0b, required 1", rx_ready);
        end
    endtask

    task automatic test_basic();
        push_valid(3'b111, 1, -25, 25);
        send_str("{\"T\":1,\"L\":-0.25,\"R\":0.25}\n");
        wait_drain("basic");
        n_checks++;
        if (left_val !== 16'hFFE7) begin
            n_fail++;
            $display("FAIL basic_left_hex: got %h, required ffe7", left_val);
        end
    endtask

    task automatic test_held();
        push_valid(3'b111, 1, 50, 50);
        send_str("{\"T\":1,\"L\":0.5,\"R\":0.5}\r\n");
        push_valid(3'b101, 1, 0, 0);
        send_str("{\"T\":1,\"R\":0}\n");
        wait_drain("held");
        n_checks++;
        if (left_val !== 16'sd50 || field_mask !== 3'b101) begin
            n_fail++;
            $display("FAIL held_left: got l=%0d m=%b, required l=50 m=101", left_val, field_mask);
        end
    endtask

    task automatic test_overflow();
        push_err();
        send_str("{\"T\":1,\"L\":12");
        send_byte(8'h33);
        n_checks++;
        if (frame_error !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_timing: got frame_error=%0b after third digit, required 1", frame_error);
        end
        send_str(",\"R\":0}\n");
        push_valid(3'b111, 2, 75, -5);
        send_str("{\"T\":2,\"L\":0.75,\"R\":-0.05}\n");
        wait_drain("overflow");
    endtask

    task automatic test_trunc();
        push_valid(3'b111, 1, 25, -100);
        send_str("{\"T\":1,\"L\":0.257,\"X\":9.9,\"R\":-1}\n");
        push_valid(3'b011, 0, 0, 0);
        send_str("{\"L\":-0,\"R\":-0.0}\n");
        push_valid(3'b110, 42, 1234, 0);
        send_str("{ \"T\" : 42.9 , \"L\":12.34, \"L\":12.34 }\n");
        wait_drain("trunc");
    endtask

    task automatic test_errors();
        string bad[6];
        bad[0] = "{\"T\":-.5}\n";
        bad[1] = "{\"L\":,\"R\":1}\n";
        bad[2] = "{\"R\":7\n";
        bad[3] = "{\"T\":{\"L\":1}\n";
        bad[4] = "{\"R\"-1}\n";
        bad[5] = "{\"L\":99.5x}\n";
        for (int i = 0; i < 6; i++) begin
            push_err();
            send_str(bad[i]);
        end
        push_valid(3'b011, 0, -9999, 9999);
        send_str("{\"L\":-99.99,\"R\":99.99}\n");
        wait_drain("errors");
    endtask

    task automatic test_timeout();
        int early = 0;
        int late  = 0;
        push_err();
        send_str("{\"T\":1,\"L\":");
        for (int k = 0; k < TMO - 10; k++) begin
            @(negedge clk);
            if (frame_error) early++;
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (frame_error) late++;
        end
        n_checks++;
        if (early != 0 || late != 1) begin
            n_fail++;
            $display("FAIL timeout_pulses: got early=%0d late=%0d, required 0 and 1", early, late);
        end
        push_valid(3'b111, 3, -150, 1);
        send_str("{\"T\":3,\"L\":-1.5,\"R\":0.01}\n");
        wait_drain("timeout");
    endtask

    task automatic test_reset_mid();
        send_str("{\"T\":4,\"L\":1");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cmd_type, left_val, right_val, field_mask, frame_valid, frame_error} !== '0 ||
            rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got cmd=%0d l=%0d r=%0d m=%b rdy=%0b, required all 0",
                     cmd_type, left_val, right_val, field_mask, rx_ready);
        end
        exp_cmd = 8'd0; exp_l = '0; exp_r = '0; exp_mask = 3'd0;
        rst = 1'b0;
        send_str("2,\"R\":3}\n");
        repeat (5) @(negedge clk);
        n_checks++;
        if ({cmd_type, left_val, right_val, field_mask} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_dropped: got cmd=%0d l=%0d r=%0d m=%b, required all 0",
                     cmd_type, left_val, right_val, field_mask);
        end
        push_valid(3'b111, 5, 100, -200);
        send_str("{\"T\":5,\"L\":1,\"R\":-2.0}\n");
        wait_drain("rstmid");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            logic [2:0] m;
            int         t, l, r;
            string      s;
            bit         first;
            m = 3'($urandom_range(0, 7));
            t = int'($urandom_range(0, 99));
            l = int'($urandom_range(0, 19998)) - 9999;
            r = int'($urandom_range(0, 19998)) - 9999;
            s = "{";
            first = 1'b1;
            if (m[2]) begin
                s = {s, $sformatf("\"T\":%0d", t)};
                first = 1'b0;
            end
            if (m[1]) begin
                s = {s, first ? "" : ",", "\"L\":", fmt_val(l)};
                first = 1'b0;
            end
            if (m[0]) begin
                s = {s, first ? "" : ",", "\"R\":", fmt_val(r)};
            end
            s = {s, "}", ($urandom_range(0, 1) == 1) ? "\r\n" : "\n"};
            push_valid(m, t, l, r);
            send_str(s);
        end
        wait_drain("b2b");
    endtask

    initial begin
        #4ms;
        n_fail++;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_held();
        test_overflow();
        test_trunc();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
